restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Sequential unsigned divider built on shift-and-subtract (restoring) iterations, one quotient bit per clock.
- It is the inverse datapath to the team's 16-bit adder/accumulator lab hardware.
- Takes a dividend and divisor from the register unit or switches and returns quotient and remainder for the hex display drivers.
- Start/Busy/Done handshake so a debounced Run button or a controller FSM can drive it.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (legal range 4..32).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a division; sampled only in IDLE.
- Dividend  input  WIDTH  unsigned dividend; captured on accepted Start.
- Divisor  input  WIDTH  unsigned divisor; captured on accepted Start.
- Quotient  output  WIDTH  registered quotient of last completed operation.
- Remainder  output  WIDTH  registered remainder of last completed operation.
- Busy  output  1  high while an operation is in progress (RUN state).
- Done  output  1  one-cycle pulse when Quotient/Remainder are updated.
- DivByZero  output  1  registered; set with Done when captured Divisor was 0.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, sampled on the rising Clk edge, and takes priority over all other inputs.
- Reset values: state=IDLE, Quotient=0, Remainder=0, Busy=0, Done=0, DivByZero=0, iteration counter=0.
- States: IDLE, RUN.
  - IDLE + Start + Divisor!=0:
    - Capture operands into internal dividend-shift, divisor and partial-remainder (=0) registers.
    - Counter=0, Busy=1, go to RUN.
  - IDLE + Start + Divisor==0:
    - Stay IDLE.
    - Next cycle: Quotient = all ones, Remainder = Dividend, DivByZero=1, Done=1. Latency 1 edge.
  - RUN, each edge:
    - trial = {partial[WIDTH-1:0], next dividend MSB}, WIDTH+1 bits.
    - If trial >= divisor: partial = trial - divisor, quotient bit = 1.
    - Else: partial = trial[WIDTH-1:0], quotient bit = 0.
    - Quotient bit shifts into the LSB of the working quotient. Counter increments.
  - RUN, iteration WIDTH (counter==WIDTH-1):
    - Load Quotient and Remainder from the working registers.
    - DivByZero=0, Done=1, Busy=0, return to IDLE.
- Latency: Start accepted at edge k → Done high in the cycle following edge k+WIDTH (17 edges for WIDTH=16). Busy high for exactly WIDTH cycles.
- Done is high for exactly one cycle; otherwise 0.
- Quotient, Remainder and DivByZero hold their last values until the next completion. Intermediate values are never visible on the outputs.
- Start while Busy: ignored. No queueing, no effect on the current operation.
- Start in the same cycle Done is high: accepted, since the state is IDLE. Back-to-back operations have zero dead cycles.
- Operand changes after capture have no effect on the operation in flight.
- Reset mid-operation: abort, everything returns to reset values, and no Done pulse is produced.
- Results always satisfy Dividend = Quotient*Divisor + Remainder with Remainder < Divisor, for Divisor != 0.
- Internal subtraction uses WIDTH+1 bits so that trial values ≥ 2^WIDTH never overflow.

Test Plan:
- Reset then Start, Dividend=100, Divisor=7 → Busy high 16 cycles; Done pulse on the 17th edge after Start; Quotient=14, Remainder=2, DivByZero=0.
- Dividend=0xFFFF, Divisor=0x0001 → Quotient=0xFFFF, Remainder=0x0000. Then Dividend=0xFFFF, Divisor=0xFFFF → Quotient=1, Remainder=0.
- Dividend=3, Divisor=10 → Quotient=0, Remainder=3. Then Dividend=0, Divisor=5 → Quotient=0, Remainder=0.
- Dividend=5, Divisor=0 → Done after 1 edge, Quotient=0xFFFF, Remainder=5, DivByZero=1, Busy never high. A following 9/2 → Quotient=4, Remainder=1, DivByZero=0.
- Start 50/5 with Start re-pulsed (operands 9/3) at cycle 5 of RUN → single Done, Quotient=10, Remainder=0. Start 9/3 held during the Done cycle → second Done 17 edges later with Quotient=3.
- Start 1000/3 then Reset at cycle 8 → all outputs 0, no Done. Start 1000/3 again → Quotient=333, Remainder=1 after 17 edges.

Source files
------------

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Start/Busy/Done handshake; a zero divisor completes in a single edge
// with Quotient all ones, Remainder = Dividend and DivByZero flagged.
module restoring_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e state;

    // shift_reg starts as the dividend; its MSB feeds each trial while
    // quotient bits enter at the LSB, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] partial;
    logic [CntW-1:0]  count;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] partial_next;
    logic [WIDTH-1:0] shift_next;

    // One restoring step: WIDTH+1-bit trial compare, then subtract or restore.
    always_comb begin
        trial        = {partial, shift_reg[WIDTH-1]};
        q_bit        = (trial >= {1'b0, divisor_reg});
        // When the subtract is taken the true result is < divisor, so the
        // low WIDTH bits of the difference are exact.
        diff         = trial[WIDTH-1:0] - divisor_reg;
        partial_next = q_bit ? diff : trial[WIDTH-1:0];
        shift_next   = {shift_reg[WIDTH-2:0], q_bit};
    end

    // Control FSM plus datapath and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            shift_reg   <= '0;
            divisor_reg <= '0;
            partial     <= '0;
            count       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            DivByZero   <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (Start) begin
                        if (Divisor != '0) begin
                            shift_reg   <= Dividend;
                            divisor_reg <= Divisor;
                            partial     <= '0;
                            count       <= '0;
                            Busy        <= 1'b1;
                            state       <= StRun;
                        end else begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    shift_reg <= shift_next;
                    partial   <= partial_next;
                    count     <= count + 1'b1;
                    if (count == LastCnt) begin
                        Quotient  <= shift_next;
                        Remainder <= partial_next;
                        DivByZero <= 1'b0;
                        Done      <= 1'b1;
                        Busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH=16) with a result scoreboard.
module tb_restoring_divider;

    localparam int unsigned W = 16;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    restoring_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           busy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   edges = 0;
    int   busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
        edges++;
        if (Busy) busy_cnt++;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        if (push) begin
            if (b == '0) begin
                e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1; e.busy = 0;
            end else begin
                e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = W + 1; e.busy = W;
            end
            sb.push_back(e);
        end
        Dividend = a;
        Divisor  = b;
        Start    = 1'b1;
        edges    = 0;
        busy_cnt = 0;
        tick();
        Start    = 1'b0;
        // Scramble operands: the operation in flight must not see them.
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        while (!Done && edges < 100) tick();
        check({tag, "_done"}, Done, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, edges, e.lat);
            check({tag, "_busy"}, busy_cnt, e.busy);
            check({tag, "_q"}, Quotient, e.q);
            check({tag, "_r"}, Remainder, e.r);
            check({tag, "_dz"}, DivByZero, e.dz);
        end
    endtask

    task automatic idle_watch(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_no_done"}, Done, 0);
            check({tag, "_no_busy"}, Busy, 0);
        end
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("rst_q", Quotient, 0);
        check("rst_r", Remainder, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_dz", DivByZero, 0);

        // Basic operation and latency
        issue(16'd100, 16'd7, 1);
        wait_done("d100_7");
        idle_watch("after_100", 2);

        // Extremes
        issue(16'hFFFF, 16'h0001, 1);
        wait_done("ffff_1");
        issue(16'hFFFF, 16'hFFFF, 1);
        wait_done("ffff_ffff");
        issue(16'd3, 16'd10, 1);
        wait_done("d3_10");
        issue(16'd0, 16'd5, 1);
        wait_done("d0_5");
        idle_watch("after_0_5", 1);

        // Divide by zero, then back-to-back normal division in the Done cycle
        issue(16'd5, 16'd0, 1);
        wait_done("d5_0");
        issue(16'd9, 16'd2, 1);
        wait_done("d9_2");
        idle_watch("after_9_2", 1);

        // Start re-pulsed while busy is ignored; Start in the Done cycle is taken
        issue(16'd50, 16'd5, 1);
        repeat (3) tick();
        Dividend = 16'd9;
        Divisor  = 16'd3;
        Start    = 1'b1;
        tick();
        Start    = 1'b0;
        wait_done("d50_5");
        issue(16'd9, 16'd3, 1);
        wait_done("d9_3");
        idle_watch("after_9_3", 20);

        // Reset mid-operation aborts without Done
        issue(16'd1000, 16'd3, 0);
        repeat (7) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort_q", Quotient, 0);
        check("abort_r", Remainder, 0);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_dz", DivByZero, 0);
        idle_watch("after_abort", 20);
        issue(16'd1000, 16'd3, 1);
        wait_done("d1000_3");

        // A few random operands checked against the bench's own arithmetic
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom_range(1, (i < 3) ? 255 : 65535));
            issue(a, b, 1);
            wait_done("rand");
        end

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
